rr_arb_stage: RTL and testbench

Round-robin arbitration stage placed directly upstream of the team's N-to-1 data multiplexer. It accepts up to N valid/ready requesters and picks one per cycle with a rotating priority pointer. It drives the multiplexer select with the winner index and registers the selected word into a single-entry output slot with valid/ready. Output is a width-bit word plus the source index, so downstream logic sees one arbitrated stream.

---
 rtl/rr_arb_pkg.sv | 35 +++
 rtl/rr_arb_stage_mux.sv | 19 +
 rtl/rr_arb_stage.sv | 68 ++++++
 tb/tb_rr_arb_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared helpers for round-robin arbitration: wrap-aware pointer increment
// and a rotating first-one scan over a request vector of up to MAX_N bits.
package rr_arb_pkg;

  localparam int unsigned MAX_N = 64;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 32'd0 : idx + 32'd1;
  endfunction

  // Scan ptr, ptr+1, ..., n-1, 0, ..., ptr-1 and report the first set bit.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] valid,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && j < MAX_N && valid[j[5:0]]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_stage_mux.sv
// N-to-1 data multiplexer; select codes at or above N produce zero.
module nto1_mux #(
  parameter  int WIDTH = 32,
  parameter  int N     = 8,
  localparam int IDXW  = $clog2(N)
) (
  input  logic [IDXW-1:0]  sel,
  input  logic [WIDTH-1:0] d [N],
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IDXW'(i)) y = d[i];
    end
  end

endmodule

// File: rtl/rr_arb_stage.sv
// Round-robin arbitration stage: rotating-priority grant into a single-entry
// output slot that feeds one arbitrated stream downstream.
module rr_arb_stage
  import rr_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 8,
  localparam int IDXW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [WIDTH-1:0] in_data [N],
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_src,
  input  logic             out_ready
);

  // Handshake: a word moves on any side when valid && ready at the rising edge;
  // valid never waits on ready, and in_ready never depends on in_data.
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  winner;
  logic             found;
  logic             load;
  rr_pick_t         pick;
  logic [WIDTH-1:0] mux_y;

  always_comb begin
    pick   = rr_pick(64'(in_valid), 32'(ptr), N);
    found  = pick.found;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (pick.idx == 32'(i)) winner = IDXW'(i);
    end
    // rst_n gates load so no requester sees ready while held in reset.
    load     = rst_n && (!out_valid || out_ready);
    in_ready = '0;
    if (found && load) in_ready[winner] = 1'b1;
  end

  nto1_mux #(
    .WIDTH(WIDTH),
    .N    (N)
  ) u_mux (
    .sel(winner),
    .d  (in_data),
    .y  (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (found && load) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= winner;
      ptr       <= IDXW'(rr_next(32'(winner), N));
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_stage.sv
// Randomized and directed bench for rr_arb_stage (N=8 and N=5 instances)
// against a modulo-arithmetic reference model and an expected-word queue.
module tb_rr_arb_stage;

  localparam int W   = 32;
  localparam int N8  = 8;
  localparam int N5  = 5;
  localparam int SBW = W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT N=8 ----------------
  logic [N8-1:0] in_valid8;
  logic [W-1:0]  in_data8 [N8];
  logic [N8-1:0] in_ready8;
  logic          out_valid8;
  logic [W-1:0]  out_data8;
  logic [2:0]    out_src8;
  logic          out_ready8;

  rr_arb_stage #(.WIDTH(W), .N(N8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_data  (in_data8),
    .in_ready (in_ready8),
    .out_valid(out_valid8),
    .out_data (out_data8),
    .out_src  (out_src8),
    .out_ready(out_ready8)
  );

  // ---------------- DUT N=5 ----------------
  logic [N5-1:0] in_valid5;
  logic [W-1:0]  in_data5 [N5];
  logic [N5-1:0] in_ready5;
  logic          out_valid5;
  logic [W-1:0]  out_data5;
  logic [2:0]    out_src5;
  logic          out_ready5;

  rr_arb_stage #(.WIDTH(W), .N(N5)) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid5),
    .in_data  (in_data5),
    .in_ready (in_ready5),
    .out_valid(out_valid5),
    .out_data (out_data5),
    .out_src  (out_src5),
    .out_ready(out_ready5)
  );

  // ---------------- scoreboard / model state ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [SBW-1:0] exp_q[$];
  logic           m_valid;
  logic [W-1:0]   m_data;
  int             m_src;
  int             m_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
    exp_q.delete();
  endtask

  // One clock of the N=8 instance: check in_ready mid-cycle, advance the
  // model, then check the registered outputs just after the edge.
  task automatic cycle8();
    int             w;
    int             idx;
    logic           found;
    logic           load;
    logic [N8-1:0]  er;
    logic [SBW-1:0] e;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_in_ready", 64'(in_ready8), 64'(0));
      check("rst_out_valid", 64'(out_valid8), 64'(0));
      check("rst_out_data", 64'(out_data8), 64'(0));
      check("rst_out_src", 64'(out_src8), 64'(0));
      @(posedge clk);
      #1;
      return;
    end
    if (out_valid8 && out_ready8) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 64'(out_data8), 64'(e[W-1:0]));
        check("sb_src", 64'(out_src8), 64'(e[SBW-1:W]));
      end
    end
    load  = !m_valid || out_ready8;
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < N8; k++) begin
      idx = (m_ptr + k) % N8;
      if (!found && ((in_valid8 >> idx) & 8'h1) != 8'h0) begin
        found = 1'b1;
        w     = idx;
      end
    end
    er = (found && load) ? N8'(1 << w) : '0;
    check("in_ready", 64'(in_ready8), 64'(er));
    if (found && load) begin
      m_data  = in_data8[w];
      m_src   = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % N8;
      exp_q.push_back({3'(w), in_data8[w]});
    end else if (load) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid8), 64'(m_valid));
    check("out_data", 64'(out_data8), 64'(m_data));
    check("out_src", 64'(out_src8), 64'(m_src));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w5;
    rst_n      = 1'b0;
    in_valid8  = '0;
    out_ready8 = 1'b1;
    for (int i = 0; i < N8; i++) in_data8[i] = 32'hA0 + 32'(i);
    in_valid5  = '0;
    out_ready5 = 1'b1;
    for (int i = 0; i < N5; i++) in_data5[i] = 32'h50 + 32'(i);
    model_reset();

    // Reset held: outputs zero, requests must not see ready.
    repeat (4) cycle8();
    in_valid8 = '1;
    cycle8();

    // Release with everyone requesting: 0..7 then wrap to 0,1.
    rst_n = 1'b1;
    repeat (10) cycle8();

    // Load a word from requester 2, then stall with requester 4 waiting.
    in_valid8 = 8'h04;
    cycle8();
    in_valid8  = 8'h10;
    out_ready8 = 1'b0;
    repeat (4) cycle8();
    out_ready8 = 1'b1;
    cycle8();
    check("stall_release_src", 64'(out_src8), 64'(4));

    // Drain with no request.
    in_valid8 = '0;
    repeat (2) cycle8();

    // Randomized traffic.
    repeat (400) begin
      in_valid8 = 8'($urandom) & 8'($urandom);
      foreach (in_data8[i]) in_data8[i] = $urandom;
      out_ready8 = ($urandom_range(0, 3) != 0);
      cycle8();
    end

    // Reset pulsed mid-burst with a word in the slot.
    in_valid8  = '1;
    out_ready8 = 1'b1;
    for (int i = 0; i < N8; i++) in_data8[i] = 32'hA0 + 32'(i);
    repeat (3) cycle8();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid8), 64'(0));
    check("async_out_data", 64'(out_data8), 64'(0));
    check("async_out_src", 64'(out_src8), 64'(0));
    model_reset();
    cycle8();
    rst_n = 1'b1;
    cycle8();
    check("first_src_after_rst", 64'(out_src8), 64'(0));

    // N=5 instance: only requesters 1 and 3, alternating from ptr 0.
    in_valid8 = '0;
    in_valid5 = 5'b01010;
    for (int k = 0; k < 6; k++) begin
      w5 = (k % 2 == 0) ? 1 : 3;
      @(negedge clk);
      check("n5_in_ready", 64'(in_ready5), 64'(1 << w5));
      @(posedge clk);
      #1;
      check("n5_out_valid", 64'(out_valid5), 64'(1));
      check("n5_out_src", 64'(out_src5), 64'(w5));
      check("n5_out_data", 64'(out_data5), 64'(32'h50 + 32'(w5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
